// File: rtl/decode_pkg.sv
// Shared types for the RV32 decode stage: opcodes, control-field encodings and the
// decoded control bundle held in the output buffer.
package decode_pkg;

   typedef enum logic [6:0] {
      OPC_LUI    = 7'b0110111,
      OPC_AUIPC  = 7'b0010111,
      OPC_JAL    = 7'b1101111,
      OPC_JALR   = 7'b1100111,
      OPC_BRANCH = 7'b1100011,
      OPC_LOAD   = 7'b0000011,
      OPC_STORE  = 7'b0100011,
      OPC_OP_IMM = 7'b0010011,
      OPC_OP     = 7'b0110011,
      OPC_SYSTEM = 7'b1110011
   } opcode_t;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_ARMED,
      ST_BLOCK
   } int_state_t;

   localparam logic [3:0] ALU_ADD      = 4'd0;
   localparam logic [3:0] ALU_LUI_COPY = 4'd9;

   localparam logic [2:0] PC_SRC_NEXT   = 3'd0;
   localparam logic [2:0] PC_SRC_JALR   = 3'd1;
   localparam logic [2:0] PC_SRC_BRANCH = 3'd2;
   localparam logic [2:0] PC_SRC_JAL    = 3'd3;
   localparam logic [2:0] PC_SRC_TRAP   = 3'd4;
   localparam logic [2:0] PC_SRC_MRET   = 3'd5;

   localparam logic [1:0] WR_SEL_PC4 = 2'd0;
   localparam logic [1:0] WR_SEL_CSR = 2'd1;
   localparam logic [1:0] WR_SEL_MEM = 2'd2;
   localparam logic [1:0] WR_SEL_ALU = 2'd3;

   localparam logic [1:0] SRCB_RS2   = 2'd0;
   localparam logic [1:0] SRCB_IMM_I = 2'd1;
   localparam logic [1:0] SRCB_IMM_S = 2'd2;
   localparam logic [1:0] SRCB_PC    = 2'd3;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic [3:0] alu_fun;
      logic       alu_srca;
      logic [1:0] alu_srcb;
      logic [2:0] pc_source;
      logic [1:0] rf_wr_sel;
      logic [2:0] func3;
      logic       reg_write;
      logic       mem_write;
      logic       mem_read;
      logic       csr_write;
      logic       branch;
      logic       illegal;
      logic       int_taken;
      logic       mdu;
   } ctrl_t;

   // Entry that replaces an instruction when an interrupt is taken: redirect only.
   function automatic ctrl_t trap_entry();
      ctrl_t c;
      c           = '0;
      c.int_taken = 1'b1;
      c.pc_source = PC_SRC_TRAP;
      return c;
   endfunction

endpackage

// File: rtl/decode_comb.sv
// Pure combinational RV32 instruction -> control bundle + immediate decoder.
// Macro DECODE_RV32M_EN enables decoding of the M-extension (FUNC7 0x01) OP encodings.
module decode_comb
   import decode_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr_i,
   output ctrl_t           ctrl_o,
   output logic [XLEN-1:0] imm_o
);

   opcode_t     opcode;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] imm32;

   assign opcode = opcode_t'(instr_i[6:0]);
   assign f3     = instr_i[14:12];
   assign f7     = instr_i[31:25];
   assign imm_o  = XLEN'($signed(imm32));

   always_comb begin
      ctrl_o       = '0;
      imm32        = '0;
      ctrl_o.rs1   = instr_i[19:15];
      ctrl_o.rs2   = instr_i[24:20];
      ctrl_o.rd    = instr_i[11:7];
      ctrl_o.func3 = f3;
      case (opcode)
         OPC_LUI: begin
            imm32            = {instr_i[31:12], 12'b0};
            ctrl_o.alu_fun   = ALU_LUI_COPY;
            ctrl_o.alu_srca  = 1'b1;
            ctrl_o.rf_wr_sel = WR_SEL_ALU;
            ctrl_o.reg_write = 1'b1;
         end
         OPC_AUIPC: begin
            imm32            = {instr_i[31:12], 12'b0};
            ctrl_o.alu_srca  = 1'b1;
            ctrl_o.alu_srcb  = SRCB_PC;
            ctrl_o.rf_wr_sel = WR_SEL_ALU;
            ctrl_o.reg_write = 1'b1;
         end
         OPC_JAL: begin
            imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                     instr_i[30:21], 1'b0};
            ctrl_o.pc_source = PC_SRC_JAL;
            ctrl_o.reg_write = 1'b1;
         end
         OPC_JALR: begin
            imm32            = {{20{instr_i[31]}}, instr_i[31:20]};
            ctrl_o.pc_source = PC_SRC_JALR;
            ctrl_o.reg_write = 1'b1;
         end
         OPC_BRANCH: begin
            // Taken/not-taken is resolved in execute; here we only mark the branch.
            imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                     instr_i[11:8], 1'b0};
            ctrl_o.branch    = 1'b1;
            ctrl_o.pc_source = PC_SRC_BRANCH;
         end
         OPC_LOAD: begin
            imm32            = {{20{instr_i[31]}}, instr_i[31:20]};
            ctrl_o.alu_srcb  = SRCB_IMM_I;
            ctrl_o.rf_wr_sel = WR_SEL_MEM;
            ctrl_o.mem_read  = 1'b1;
            ctrl_o.reg_write = 1'b1;
         end
         OPC_STORE: begin
            imm32            = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            ctrl_o.alu_srcb  = SRCB_IMM_S;
            ctrl_o.mem_write = 1'b1;
         end
         OPC_OP_IMM: begin
            imm32            = {{20{instr_i[31]}}, instr_i[31:20]};
            ctrl_o.alu_fun   = {f7[5] & (f3 == 3'd5), f3};
            ctrl_o.alu_srcb  = SRCB_IMM_I;
            ctrl_o.rf_wr_sel = WR_SEL_ALU;
            ctrl_o.reg_write = 1'b1;
         end
         OPC_OP: begin
            if (f7 == 7'h00 || f7 == 7'h20) begin
               ctrl_o.alu_fun   = {f7[5], f3};
               ctrl_o.rf_wr_sel = WR_SEL_ALU;
               ctrl_o.reg_write = 1'b1;
            end
`ifdef DECODE_RV32M_EN
            else if (f7 == 7'h01) begin
               ctrl_o.mdu       = 1'b1;
               ctrl_o.alu_fun   = {1'b0, f3};
               ctrl_o.rf_wr_sel = WR_SEL_ALU;
               ctrl_o.reg_write = 1'b1;
            end
`endif
            else begin
               ctrl_o.illegal = 1'b1;
            end
         end
         OPC_SYSTEM: begin
            imm32            = {{20{instr_i[31]}}, instr_i[31:20]};
            ctrl_o.alu_fun   = ALU_LUI_COPY;
            ctrl_o.rf_wr_sel = WR_SEL_CSR;
            if (f3 == 3'd0) begin
               ctrl_o.pc_source = PC_SRC_MRET;
            end else begin
               ctrl_o.csr_write = 1'b1;
               ctrl_o.reg_write = 1'b1;
            end
         end
         default: begin
            ctrl_o.illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32 decode stage: BUF_DEPTH-entry output buffer, fetch/execute handshakes,
// flush and interrupt injection. Macro DECODE_RV32M_EN (in decode_comb) enables M decode.
module decode_stage
   import decode_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int BUF_DEPTH = 2
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic            IF_VALID,
   output logic            IF_READY,
   input  logic [31:0]     IF_INSTR,
   input  logic [XLEN-1:0] IF_PC,
   input  logic            FLUSH,
   input  logic            INT_REQ,
   input  logic            INT_EN,
   output logic            ID_VALID,
   input  logic            ID_READY,
   output logic [XLEN-1:0] ID_PC,
   output logic [XLEN-1:0] ID_IMM,
   output logic [4:0]      ID_RS1,
   output logic [4:0]      ID_RS2,
   output logic [4:0]      ID_RD,
   output logic [3:0]      ID_ALU_FUN,
   output logic            ID_ALU_SRCA,
   output logic [1:0]      ID_ALU_SRCB,
   output logic [2:0]      ID_PC_SOURCE,
   output logic [1:0]      ID_RF_WR_SEL,
   output logic [2:0]      ID_FUNC3,
   output logic            ID_REG_WRITE,
   output logic            ID_MEM_WRITE,
   output logic            ID_MEM_READ,
   output logic            ID_CSR_WRITE,
   output logic            ID_BRANCH,
   output logic            ID_ILLEGAL,
   output logic            ID_INT_TAKEN,
   output logic            ID_MDU
);

   localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CNT_W = $clog2(BUF_DEPTH + 1);

   ctrl_t           dec_ctrl;
   logic [XLEN-1:0] dec_imm;
   ctrl_t           entry_ctrl;
   logic [XLEN-1:0] entry_imm;
   ctrl_t           head_ctrl;
   logic [XLEN-1:0] head_pc;
   logic [XLEN-1:0] head_imm;

   ctrl_t           buf_ctrl_q [BUF_DEPTH];
   logic [XLEN-1:0] buf_pc_q   [BUF_DEPTH];
   logic [XLEN-1:0] buf_imm_q  [BUF_DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   int_state_t       state_q;
   logic             push;
   logic             pop;

   decode_comb #(.XLEN(XLEN)) u_decode_comb (
      .instr_i (IF_INSTR),
      .ctrl_o  (dec_ctrl),
      .imm_o   (dec_imm)
   );

   assign IF_READY = (count_q < CNT_W'(BUF_DEPTH)) && RST_N && !FLUSH;
   assign ID_VALID = (count_q != '0);
   assign push     = IF_VALID && IF_READY;
   assign pop      = ID_VALID && ID_READY && !FLUSH;

   // While armed, the next accepted instruction becomes the interrupt entry.
   assign entry_ctrl = (state_q == ST_ARMED) ? trap_entry() : dec_ctrl;
   assign entry_imm  = (state_q == ST_ARMED) ? '0 : dec_imm;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (FLUSH) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(BUF_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(BUF_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (push) begin
         buf_ctrl_q[wr_ptr_q] <= entry_ctrl;
         buf_pc_q[wr_ptr_q]   <= IF_PC;
         buf_imm_q[wr_ptr_q]  <= entry_imm;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q <= ST_RUN;
      end else begin
         case (state_q)
            ST_RUN:   if (INT_REQ && INT_EN) state_q <= ST_ARMED;
            ST_ARMED: begin
               if (push)         state_q <= ST_BLOCK;
               else if (!INT_EN) state_q <= ST_RUN;
            end
            ST_BLOCK: if (!INT_REQ) state_q <= ST_RUN;
            default:  state_q <= ST_RUN;
         endcase
      end
   end

   // Empty buffer presents an all-zero bundle, which also covers the reset state.
   assign head_ctrl = ID_VALID ? buf_ctrl_q[rd_ptr_q] : '0;
   assign head_pc   = ID_VALID ? buf_pc_q[rd_ptr_q]   : '0;
   assign head_imm  = ID_VALID ? buf_imm_q[rd_ptr_q]  : '0;

   assign ID_PC        = head_pc;
   assign ID_IMM       = head_imm;
   assign ID_RS1       = head_ctrl.rs1;
   assign ID_RS2       = head_ctrl.rs2;
   assign ID_RD        = head_ctrl.rd;
   assign ID_ALU_FUN   = head_ctrl.alu_fun;
   assign ID_ALU_SRCA  = head_ctrl.alu_srca;
   assign ID_ALU_SRCB  = head_ctrl.alu_srcb;
   assign ID_PC_SOURCE = head_ctrl.pc_source;
   assign ID_RF_WR_SEL = head_ctrl.rf_wr_sel;
   assign ID_FUNC3     = head_ctrl.func3;
   assign ID_REG_WRITE = head_ctrl.reg_write;
   assign ID_MEM_WRITE = head_ctrl.mem_write;
   assign ID_MEM_READ  = head_ctrl.mem_read;
   assign ID_CSR_WRITE = head_ctrl.csr_write;
   assign ID_BRANCH    = head_ctrl.branch;
   assign ID_ILLEGAL   = head_ctrl.illegal;
   assign ID_INT_TAKEN = head_ctrl.int_taken;
   assign ID_MDU       = head_ctrl.mdu;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage (XLEN 32, BUF_DEPTH 2).
module tb_decode_stage;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        IF_VALID = 1'b0;
   logic        IF_READY;
   logic [31:0] IF_INSTR = '0;
   logic [31:0] IF_PC = '0;
   logic        FLUSH = 1'b0;
   logic        INT_REQ = 1'b0;
   logic        INT_EN = 1'b0;
   logic        ID_VALID;
   logic        ID_READY = 1'b0;
   logic [31:0] ID_PC, ID_IMM;
   logic [4:0]  ID_RS1, ID_RS2, ID_RD;
   logic [3:0]  ID_ALU_FUN;
   logic        ID_ALU_SRCA;
   logic [1:0]  ID_ALU_SRCB;
   logic [2:0]  ID_PC_SOURCE;
   logic [1:0]  ID_RF_WR_SEL;
   logic [2:0]  ID_FUNC3;
   logic ID_REG_WRITE, ID_MEM_WRITE, ID_MEM_READ, ID_CSR_WRITE;
   logic ID_BRANCH, ID_ILLEGAL, ID_INT_TAKEN, ID_MDU;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   decode_stage #(.XLEN(32), .BUF_DEPTH(2)) dut (
      .CLK(CLK), .RST_N(RST_N), .IF_VALID(IF_VALID), .IF_READY(IF_READY),
      .IF_INSTR(IF_INSTR), .IF_PC(IF_PC), .FLUSH(FLUSH), .INT_REQ(INT_REQ),
      .INT_EN(INT_EN), .ID_VALID(ID_VALID), .ID_READY(ID_READY), .ID_PC(ID_PC),
      .ID_IMM(ID_IMM), .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_RD(ID_RD),
      .ID_ALU_FUN(ID_ALU_FUN), .ID_ALU_SRCA(ID_ALU_SRCA), .ID_ALU_SRCB(ID_ALU_SRCB),
      .ID_PC_SOURCE(ID_PC_SOURCE), .ID_RF_WR_SEL(ID_RF_WR_SEL), .ID_FUNC3(ID_FUNC3),
      .ID_REG_WRITE(ID_REG_WRITE), .ID_MEM_WRITE(ID_MEM_WRITE), .ID_MEM_READ(ID_MEM_READ),
      .ID_CSR_WRITE(ID_CSR_WRITE), .ID_BRANCH(ID_BRANCH), .ID_ILLEGAL(ID_ILLEGAL),
      .ID_INT_TAKEN(ID_INT_TAKEN), .ID_MDU(ID_MDU)
   );

   // flags = {reg_write, mem_write, mem_read, csr_write, branch, illegal, mdu}
   typedef struct {
      logic [31:0] instr;
      logic [31:0] imm;
      logic [3:0]  alu;
      logic        srca;
      logic [1:0]  srcb;
      logic [2:0]  pcs;
      logic [1:0]  wrs;
      logic [6:0]  flags;
   } vec_t;

   // Drive one instruction for one cycle; returns at the following negedge.
   task automatic push_one(input logic [31:0] instr, input logic [31:0] pc);
      IF_VALID = 1'b1;
      IF_INSTR = instr;
      IF_PC    = pc;
      @(negedge CLK);
      IF_VALID = 1'b0;
   endtask

   task automatic test_reset();
      RST_N = 1'b0; IF_VALID = 1'b1; IF_INSTR = 32'h00500093; IF_PC = 32'h40;
      repeat (2) @(negedge CLK);
      checks++; if (ID_VALID !== 1'b0) begin errors++; $display("FAIL reset_id_valid: got %b want 0", ID_VALID); end
      checks++; if (IF_READY !== 1'b0) begin errors++; $display("FAIL reset_if_ready: got %b want 0", IF_READY); end
      checks++;
      if ({ID_PC, ID_IMM, ID_RD, ID_ALU_FUN, ID_PC_SOURCE, ID_REG_WRITE, ID_INT_TAKEN} !== '0) begin
         errors++; $display("FAIL reset_outputs: got pc=%h imm=%h rd=%0d alu=%0d pcs=%0d rw=%b it=%b want all 0",
                             ID_PC, ID_IMM, ID_RD, ID_ALU_FUN, ID_PC_SOURCE, ID_REG_WRITE, ID_INT_TAKEN);
      end
      RST_N = 1'b1; IF_VALID = 1'b0;
      #1;
      checks++; if (IF_READY !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", IF_READY); end
      $display("test_reset done");
   endtask

   task automatic test_addi();
      ID_READY = 1'b1;
      push_one(32'h00500093, 32'h80);
      checks++; if (ID_VALID !== 1'b1) begin errors++; $display("FAIL addi_valid: got %b want 1", ID_VALID); end
      checks++;
      if ({ID_ALU_FUN, ID_ALU_SRCB, ID_RD, ID_RS1, ID_REG_WRITE, ID_RF_WR_SEL} !== {4'd0, 2'd1, 5'd1, 5'd0, 1'b1, 2'd3}) begin
         errors++; $display("FAIL addi_ctrl: got alu=%0d srcb=%0d rd=%0d rs1=%0d rw=%b wrs=%0d want 0 1 1 0 1 3",
                             ID_ALU_FUN, ID_ALU_SRCB, ID_RD, ID_RS1, ID_REG_WRITE, ID_RF_WR_SEL);
      end
      checks++; if (ID_IMM !== 32'd5) begin errors++; $display("FAIL addi_imm: got %h want 00000005", ID_IMM); end
      checks++; if (ID_PC !== 32'h80) begin errors++; $display("FAIL addi_pc: got %h want 00000080", ID_PC); end
      @(negedge CLK);
      checks++; if (ID_VALID !== 1'b0) begin errors++; $display("FAIL addi_popped: got %b want 0", ID_VALID); end
      $display("test_addi done");
   endtask

   task automatic test_decode();
      vec_t v[14];
      v[0]  = '{32'h12345137, 32'h12345000, 4'd9,  1'b1, 2'd0, 3'd0, 2'd3, 7'b1000000}; // lui
      v[1]  = '{32'hFE512E23, 32'hFFFFFFFC, 4'd0,  1'b0, 2'd2, 3'd0, 2'd0, 7'b0100000}; // sw
      v[2]  = '{32'hFE000CE3, 32'hFFFFFFF8, 4'd0,  1'b0, 2'd0, 3'd2, 2'd0, 7'b0000100}; // beq
      v[3]  = '{32'h010000EF, 32'h00000010, 4'd0,  1'b0, 2'd0, 3'd3, 2'd0, 7'b1000000}; // jal
      v[4]  = '{32'h00802183, 32'h00000008, 4'd0,  1'b0, 2'd1, 3'd0, 2'd2, 7'b1010000}; // lw
      v[5]  = '{32'h402081B3, 32'h00000000, 4'd8,  1'b0, 2'd0, 3'd0, 2'd3, 7'b1000000}; // sub
      v[6]  = '{32'h4030D093, 32'h00000403, 4'd13, 1'b0, 2'd1, 3'd0, 2'd3, 7'b1000000}; // srai
      v[7]  = '{32'h300312F3, 32'h00000300, 4'd9,  1'b0, 2'd0, 3'd0, 2'd1, 7'b1001000}; // csrrw
      v[8]  = '{32'h30200073, 32'h00000302, 4'd9,  1'b0, 2'd0, 3'd5, 2'd1, 7'b0000000}; // mret
      v[9]  = '{32'h0000007F, 32'h00000000, 4'd0,  1'b0, 2'd0, 3'd0, 2'd0, 7'b0000010}; // bad opcode
      v[10] = '{32'h20000033, 32'h00000000, 4'd0,  1'b0, 2'd0, 3'd0, 2'd0, 7'b0000010}; // OP f7=0x10
      v[11] = '{32'hFFFFF217, 32'hFFFFF000, 4'd0,  1'b1, 2'd3, 3'd0, 2'd3, 7'b1000000}; // auipc
      v[12] = '{32'h00408067, 32'h00000004, 4'd0,  1'b0, 2'd0, 3'd1, 2'd0, 7'b1000000}; // jalr
      v[13] = '{32'hFFF00093, 32'hFFFFFFFF, 4'd0,  1'b0, 2'd1, 3'd0, 2'd3, 7'b1000000}; // addi -1
      ID_READY = 1'b1;
      for (int i = 0; i < 14; i++) begin
         push_one(v[i].instr, 32'h1000 + 32'(i * 4));
         checks++;
         if (ID_IMM !== v[i].imm) begin
            errors++; $display("FAIL decode_imm[%0d]: got %h want %h", i, ID_IMM, v[i].imm);
         end
         checks++;
         if ({ID_VALID, ID_ALU_FUN, ID_ALU_SRCA, ID_ALU_SRCB, ID_PC_SOURCE, ID_RF_WR_SEL,
              ID_REG_WRITE, ID_MEM_WRITE, ID_MEM_READ, ID_CSR_WRITE, ID_BRANCH, ID_ILLEGAL, ID_MDU}
             !== {1'b1, v[i].alu, v[i].srca, v[i].srcb, v[i].pcs, v[i].wrs, v[i].flags}) begin
            errors++;
            $display("FAIL decode_ctrl[%0d]: got v=%b alu=%0d a=%b b=%0d pcs=%0d wrs=%0d fl=%b want v=1 alu=%0d a=%b b=%0d pcs=%0d wrs=%0d fl=%b",
                     i, ID_VALID, ID_ALU_FUN, ID_ALU_SRCA, ID_ALU_SRCB, ID_PC_SOURCE, ID_RF_WR_SEL,
                     {ID_REG_WRITE, ID_MEM_WRITE, ID_MEM_READ, ID_CSR_WRITE, ID_BRANCH, ID_ILLEGAL, ID_MDU},
                     v[i].alu, v[i].srca, v[i].srcb, v[i].pcs, v[i].wrs, v[i].flags);
         end
         $display("decode[%0d] instr=%h imm=%h alu=%0d pcs=%0d", i, v[i].instr, ID_IMM, ID_ALU_FUN, ID_PC_SOURCE);
      end
      @(negedge CLK);
      $display("test_decode done");
   endtask

   task automatic test_back_to_back();
      ID_READY = 1'b0;
      IF_VALID = 1'b1; IF_INSTR = 32'h00100093; IF_PC = 32'h10;
      @(negedge CLK);
      checks++; if (IF_READY !== 1'b1 || ID_PC !== 32'h10) begin errors++; $display("FAIL full_first: got rdy=%b pc=%h want 1 00000010", IF_READY, ID_PC); end
      IF_INSTR = 32'h00200093; IF_PC = 32'h14;
      @(negedge CLK);
      checks++; if (IF_READY !== 1'b0 || ID_PC !== 32'h10) begin errors++; $display("FAIL full_second: got rdy=%b pc=%h want 0 00000010", IF_READY, ID_PC); end
      IF_INSTR = 32'h00300093; IF_PC = 32'h18;
      @(negedge CLK);
      checks++; if (IF_READY !== 1'b0 || ID_PC !== 32'h10 || ID_IMM !== 32'd1) begin errors++; $display("FAIL full_stall: got rdy=%b pc=%h imm=%h want 0 00000010 00000001", IF_READY, ID_PC, ID_IMM); end
      ID_READY = 1'b1;
      @(negedge CLK);
      checks++; if (IF_READY !== 1'b1 || ID_PC !== 32'h14 || ID_IMM !== 32'd2) begin errors++; $display("FAIL full_pop1: got rdy=%b pc=%h imm=%h want 1 00000014 00000002", IF_READY, ID_PC, ID_IMM); end
      @(negedge CLK);
      IF_VALID = 1'b0;
      checks++; if (ID_VALID !== 1'b1 || ID_PC !== 32'h18 || ID_IMM !== 32'd3) begin errors++; $display("FAIL full_pushpop: got v=%b pc=%h imm=%h want 1 00000018 00000003", ID_VALID, ID_PC, ID_IMM); end
      @(negedge CLK);
      checks++; if (ID_VALID !== 1'b0) begin errors++; $display("FAIL full_drained: got %b want 0", ID_VALID); end
      $display("test_back_to_back done");
   endtask

   task automatic test_interrupt();
      ID_READY = 1'b1; INT_REQ = 1'b1; INT_EN = 1'b1;
      @(negedge CLK);
      push_one(32'h00500093, 32'h100);
      checks++;
      if ({ID_VALID, ID_INT_TAKEN, ID_PC_SOURCE, ID_REG_WRITE, ID_ILLEGAL} !== {1'b1, 1'b1, 3'd4, 1'b0, 1'b0} || ID_PC !== 32'h100) begin
         errors++; $display("FAIL int_inject: got v=%b it=%b pcs=%0d rw=%b ill=%b pc=%h want 1 1 4 0 0 00000100",
                             ID_VALID, ID_INT_TAKEN, ID_PC_SOURCE, ID_REG_WRITE, ID_ILLEGAL, ID_PC);
      end
      push_one(32'h00500093, 32'h104);
      checks++;
      if ({ID_INT_TAKEN, ID_PC_SOURCE, ID_REG_WRITE} !== {1'b0, 3'd0, 1'b1} || ID_PC !== 32'h104) begin
         errors++; $display("FAIL int_block: got it=%b pcs=%0d rw=%b pc=%h want 0 0 1 00000104", ID_INT_TAKEN, ID_PC_SOURCE, ID_REG_WRITE, ID_PC);
      end
      INT_REQ = 1'b0;
      @(negedge CLK);
      INT_REQ = 1'b1;
      @(negedge CLK);
      INT_EN = 1'b0;
      @(negedge CLK);
      push_one(32'h00500093, 32'h108);
      checks++;
      if (ID_INT_TAKEN !== 1'b0 || ID_REG_WRITE !== 1'b1) begin
         errors++; $display("FAIL int_disarm: got it=%b rw=%b want 0 1", ID_INT_TAKEN, ID_REG_WRITE);
      end
      INT_REQ = 1'b0;
      @(negedge CLK);
      $display("test_interrupt done");
   endtask

   task automatic test_flush();
      ID_READY = 1'b0;
      push_one(32'h00100093, 32'h200);
      push_one(32'h00200093, 32'h204);
      checks++; if (ID_VALID !== 1'b1 || ID_PC !== 32'h200) begin errors++; $display("FAIL flush_pre: got v=%b pc=%h want 1 00000200", ID_VALID, ID_PC); end
      FLUSH = 1'b1; IF_VALID = 1'b1; IF_INSTR = 32'h00300093; IF_PC = 32'h208;
      #1;
      checks++; if (IF_READY !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", IF_READY); end
      @(negedge CLK);
      FLUSH = 1'b0; IF_VALID = 1'b0;
      checks++; if (ID_VALID !== 1'b0) begin errors++; $display("FAIL flush_empty: got %b want 0", ID_VALID); end
      push_one(32'h00400093, 32'h20C);
      checks++; if (ID_PC !== 32'h20C || ID_IMM !== 32'd4) begin errors++; $display("FAIL flush_after: got pc=%h imm=%h want 0000020c 00000004", ID_PC, ID_IMM); end
      ID_READY = 1'b1;
      @(negedge CLK);
      checks++; if (ID_VALID !== 1'b0) begin errors++; $display("FAIL flush_dropped: got %b want 0", ID_VALID); end
      $display("test_flush done");
   endtask

   task automatic test_mul();
      ID_READY = 1'b1;
      push_one(32'h02208033, 32'h300);
`ifdef DECODE_RV32M_EN
      checks++;
      if ({ID_MDU, ID_ILLEGAL, ID_REG_WRITE, ID_ALU_FUN, ID_RF_WR_SEL} !== {1'b1, 1'b0, 1'b1, 4'd0, 2'd3}) begin
         errors++; $display("FAIL mul_decode: got mdu=%b ill=%b rw=%b alu=%0d wrs=%0d want 1 0 1 0 3", ID_MDU, ID_ILLEGAL, ID_REG_WRITE, ID_ALU_FUN, ID_RF_WR_SEL);
      end
`else
      checks++;
      if ({ID_MDU, ID_ILLEGAL, ID_REG_WRITE, ID_PC_SOURCE} !== {1'b0, 1'b1, 1'b0, 3'd0}) begin
         errors++; $display("FAIL mul_illegal: got mdu=%b ill=%b rw=%b pcs=%0d want 0 1 0 0", ID_MDU, ID_ILLEGAL, ID_REG_WRITE, ID_PC_SOURCE);
      end
`endif
      @(negedge CLK);
      $display("test_mul done");
   endtask

   task automatic test_mid_reset();
      ID_READY = 1'b0;
      push_one(32'h00100093, 32'h400);
      RST_N = 1'b0;
      @(negedge CLK);
      checks++; if (ID_VALID !== 1'b0 || IF_READY !== 1'b0) begin errors++; $display("FAIL midreset: got v=%b rdy=%b want 0 0", ID_VALID, IF_READY); end
      RST_N = 1'b1;
      @(negedge CLK);
      checks++; if (ID_VALID !== 1'b0 || IF_READY !== 1'b1) begin errors++; $display("FAIL midreset_release: got v=%b rdy=%b want 0 1", ID_VALID, IF_READY); end
      $display("test_mid_reset done");
   endtask

   initial begin
      test_reset();
      test_addi();
      test_decode();
      test_back_to_back();
      test_interrupt();
      test_flush();
      test_mul();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised instruction-decode stage for the pipelined RV32 core, sitting between fetch and execute. Each accepted instruction is decoded into a full control bundle (ALU/PC/RF/memory/CSR selects, register indices, sign-extended immediate) and held in a BUF_DEPTH-entry output buffer with valid/ready handshakes on both sides. Branch resolution moves to execute. New relative to the single-cycle decoder: flush, illegal-instruction flagging, and interrupt injection via a small FSM.

## Interface
- XLEN, 32, datapath/PC/immediate width
- BUF_DEPTH, 2, output buffer entries (≥1)
- CLK  in  1  clock
- RST_N  in  1  reset, synchronous, active-low
- IF_VALID / IF_READY  in / out  1  fetch handshake
- IF_INSTR  in  32  instruction; IF_PC  in  XLEN  its PC
- FLUSH  in  1  discard all buffered entries
- INT_REQ  in  1  interrupt request level; INT_EN  in  1  global enable (mstatus.MIE)
- ID_VALID / ID_READY  out / in  1  execute handshake
- ID_PC  out  XLEN; ID_IMM  out  XLEN; ID_RS1, ID_RS2, ID_RD  out  5 each
- ID_ALU_FUN  out  4; ID_ALU_SRCA  out  1; ID_ALU_SRCB  out  2; ID_PC_SOURCE  out  3; ID_RF_WR_SEL  out  2; ID_FUNC3  out  3
- ID_REG_WRITE, ID_MEM_WRITE, ID_MEM_READ, ID_CSR_WRITE, ID_BRANCH, ID_ILLEGAL, ID_INT_TAKEN, ID_MDU  out  1 each

## Operation
- Push on IF_VALID && IF_READY; pop on ID_VALID && ID_READY. IF_READY = (count < BUF_DEPTH) && RST_N && !FLUSH. ID outputs show head entry; ID_VALID = (count ≠ 0).
- Decode (others 0): LUI ALU_FUN 9, SRCA 1, WR_SEL 3, REG_WRITE. AUIPC SRCA 1, SRCB 3, WR_SEL 3, REG_WRITE. JAL PC_SOURCE 3, REG_WRITE. JALR PC_SOURCE 1, REG_WRITE. BRANCH ID_BRANCH 1, PC_SOURCE 2 (taken decided in execute). LOAD SRCB 1, WR_SEL 2, MEM_READ, REG_WRITE. STORE SRCB 2, MEM_WRITE. OP_IMM ALU_FUN {FUNC7[5]&(FUNC3==5), FUNC3}, SRCB 1, WR_SEL 3, REG_WRITE. OP ALU_FUN {FUNC7[5], FUNC3}, WR_SEL 3, REG_WRITE. SYSTEM ALU_FUN 9, WR_SEL 1; FUNC3==0 → PC_SOURCE 5 (mret); else CSR_WRITE, REG_WRITE.
- Immediate: I/S/B/U/J formats, sign-extended from bit 31 to XLEN; 0 for OP.
- Unknown opcode, or OP with FUNC7 ∉ {0x00, 0x20} (and not M when enabled): ID_ILLEGAL 1, all write/read enables 0, PC_SOURCE 0.
- Interrupt FSM, states RUN, ARMED, BLOCK:
  - RUN → ARMED when INT_REQ && INT_EN.
  - ARMED: next pushed instruction is replaced by an injection entry: ID_INT_TAKEN 1, PC_SOURCE 4, ID_PC = that instruction's PC, all enables 0. → BLOCK on that push.
  - BLOCK → RUN when INT_REQ deasserts.
  - ARMED → RUN if INT_EN drops before a push.
- FLUSH: count ← 0 next edge; the same-cycle push is dropped; FSM state unchanged.

## Timing
- Latency 1: pushed at edge N → on ID outputs after edge N (with an empty buffer).
- Full: IF_READY 0; push and pop in the same cycle allowed only when not full. There is no pass-through.
- Simultaneous push+pop with 0 < count < BUF_DEPTH: count unchanged, order preserved.
- Pointers wrap modulo BUF_DEPTH; count width is $clog2(BUF_DEPTH+1).
- Reset (RST_N low at edge): count 0, FSM RUN, all ID outputs 0, IF_READY 0 while low. Mid-operation reset discards buffered entries.
- FLUSH and RST_N take precedence over push/pop. ID outputs are stable while ID_VALID && !ID_READY.

## Configuration
- DECODE_RV32M_EN defined: OP with FUNC7 0x01 → ID_MDU 1, ALU_FUN {1'b0, FUNC3}, WR_SEL 3, REG_WRITE, not illegal.
- Undefined: ID_MDU is tied 0 and those encodings set ID_ILLEGAL.

## Structure
- Package decode_pkg: opcode_t enum, ALU_FUN / PC_SOURCE / RF_WR_SEL / ALU_SRCB constants, and the packed decoded-bundle struct stored in the buffer.
- One sub-module, decode_comb: a pure combinational instruction → bundle function. decode_stage holds the buffer, handshake and FSM.

## Test plan
- Reset: hold RST_N low 2 cycles with IF_VALID 1 → ID_VALID 0, IF_READY 0, all outputs 0; release → IF_READY 1.
- Push 0x00500093 (addi x1,x0,5) with ID_READY 1 → next cycle ID_VALID 1, ALU_FUN 0, SRCB 1, RD 1, IMM 5, REG_WRITE 1.
- ID_READY 0, push 3 instructions with BUF_DEPTH 2 → IF_READY 0 after 2; release ID_READY → pops in order, no loss or duplication.
- INT_REQ 1, INT_EN 1, then push PC 0x100 → entry has ID_INT_TAKEN 1, PC_SOURCE 4, ID_PC 0x100; following pushes decode normally until INT_REQ toggles.
- Buffer holding 2 entries, FLUSH with a simultaneous push → next cycle ID_VALID 0, count 0.
- Push 0x02208033 (mul) → ID_MDU 1 with DECODE_RV32M_EN defined; ID_ILLEGAL 1 without it.
